cache_arbiter: RTL

Shares one physical-memory port between the I-cache and D-cache miss paths of the pipelined LC-3b. It accepts one line-wide request (read or write of one 128-bit lc3b_c_line) from each cache. It grants one request at a time, forwards that request to physical memory, and returns the response to the granted cache only. It sits between the two caches' pmem-side interfaces and the memory model.

---
 rtl/cache_arbiter_pkg.sv | 29 ++
 rtl/cache_arbiter_if.sv | 47 ++++
 rtl/cache_arbiter_grant.sv | 31 +++
 rtl/cache_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter.
// Line and address widths follow the LC-3b cache types.
package cache_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int OFFS_W = 4;

  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_c_line;
  typedef logic [OFFS_W-1:0] lc3b_c_offset;

  typedef enum logic [1:0] {
    arb_idle,
    arb_serve_i,
    arb_serve_d
  } lc3b_arb_state;

  typedef logic lc3b_arb_sel;
  localparam lc3b_arb_sel SEL_I = 1'b0;
  localparam lc3b_arb_sel SEL_D = 1'b1;

  function automatic lc3b_word line_align(
    input lc3b_word a
  );
    return {a[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Cache-side and pmem-side signals of the arbiter.
// master = arbiter view, slave = caches + memory view.
interface cache_arbiter_if;
  import cache_arbiter_pkg::*;

  logic       i_read;
  lc3b_word   i_address;
  lc3b_c_line i_rdata;
  logic       i_resp;

  logic       d_read;
  logic       d_write;
  lc3b_word   d_address;
  lc3b_c_line d_wdata;
  lc3b_c_line d_rdata;
  logic       d_resp;

  logic       pmem_read;
  logic       pmem_write;
  lc3b_word   pmem_address;
  lc3b_c_line pmem_wdata;
  lc3b_c_line pmem_rdata;
  logic       pmem_resp;

  modport master (
    input  i_read, i_address,
    input  d_read, d_write,
    input  d_address, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata
  );

  modport slave (
    output i_read, i_address,
    output d_read, d_write,
    output d_address, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter_grant.sv
// Grant selection. CACHE_ARB_RR_EN: round-robin on contention,
// otherwise fixed D-over-I priority.
module cache_arbiter_grant
  import cache_arbiter_pkg::*;
(
  input  logic        i_req_i,
  input  logic        d_req_i,
`ifdef CACHE_ARB_RR_EN
  input  lc3b_arb_sel ptr_i,
`endif
  output logic        grant_valid_o,
  output lc3b_arb_sel grant_sel_o
);

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_sel_o   = SEL_I;
    unique case (1'b1)
      (i_req_i & d_req_i): begin
`ifdef CACHE_ARB_RR_EN
        grant_sel_o = ptr_i;
`else
        grant_sel_o = SEL_D;
`endif
      end
      (d_req_i & ~i_req_i): grant_sel_o = SEL_D;
      default:              grant_sel_o = SEL_I;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem port between I-cache and D-cache miss paths.
// Optional round-robin contention policy: CACHE_ARB_RR_EN.
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cache_arbiter_if.master bus
);

  lc3b_arb_state state_q, state_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  lc3b_word      addr_q, addr_d;
  lc3b_c_line    wdata_q, wdata_d;
  logic          i_req, d_req;
  logic          grant_valid;
  lc3b_arb_sel   grant_sel;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARB_RR_EN
  lc3b_arb_sel ptr_q, ptr_d;
`endif

  cache_arbiter_grant u_grant (
    .i_req_i       (i_req),
    .d_req_i       (d_req),
`ifdef CACHE_ARB_RR_EN
    .ptr_i         (ptr_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_sel_o   (grant_sel)
  );

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;
  assign bus.i_resp = (state_q == arb_serve_i) & bus.pmem_resp;
  assign bus.d_resp = (state_q == arb_serve_d) & bus.pmem_resp;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef CACHE_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      arb_idle: begin
        if (grant_valid) begin
`ifdef CACHE_ARB_RR_EN
          ptr_d = ~grant_sel;
`endif
          if (grant_sel == SEL_D) begin
            state_d = arb_serve_d;
            addr_d  = line_align(bus.d_address);
            // read+write together is treated as a writeback
            wr_d    = bus.d_write;
            rd_d    = ~bus.d_write;
            if (bus.d_write) wdata_d = bus.d_wdata;
          end else begin
            state_d = arb_serve_i;
            addr_d  = line_align(bus.i_address);
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end
      end
      arb_serve_i, arb_serve_d: begin
        if (bus.pmem_resp) begin
          state_d = arb_idle;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = arb_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= arb_idle;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef CACHE_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SEL_I;
    else        ptr_q <= ptr_d;
  end
`endif

  a_d_rw_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.d_read && bus.d_write)
  ) else $error("d_read and d_write asserted together");

endmodule
